// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
//   Constants shared by the GCD unit and the operand FIFO placed in front of
//   it, so both sides of the operands_* interface agree on width and depth.
//   No ports (package).
// ---------------------------------------------------------------------------
package gcd_pkg;

   // Operand width used by the GCD unit and everything feeding it.
   localparam int GCD_W = 32;

   // Number of (A, B) pairs buffered ahead of the GCD unit.
   localparam int GCD_FIFO_DEPTH = 4;

endpackage : gcd_pkg

// File: rtl/gcd_operand_fifo.sv
// ---------------------------------------------------------------------------
// gcd_operand_fifo
//   In-order buffer of (A, B) operand pairs in front of the GCD unit. Absorbs
//   producer bursts while the GCD unit iterates on the current pair.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high; clears pointers, count, storage
//   in_bits_A/B      operand pair from the producer
//   in_val / in_rdy  producer handshake; pair stored when both are high
//   operands_bits_A/B  head-of-queue pair, wired straight to the GCD unit
//   operands_val / operands_rdy  GCD handshake; head popped when both high
//   count            number of stored pairs (0..DEPTH)
//
// in_rdy and operands_val are derived only from the registered count, so
// there is no combinational path from either handshake input to the other
// side. A full FIFO refuses a pair even if the head is popped that cycle.
// ---------------------------------------------------------------------------
module gcd_operand_fifo
   import gcd_pkg::*;
#(
   parameter  int W     = GCD_W,
   parameter  int DEPTH = GCD_FIFO_DEPTH,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  in_bits_A,
   input  logic [W-1:0]  in_bits_B,
   input  logic          in_val,
   output logic          in_rdy,
   output logic [W-1:0]  operands_bits_A,
   output logic [W-1:0]  operands_bits_B,
   output logic          operands_val,
   input  logic          operands_rdy,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [W-1:0]  mem_a [DEPTH];
   logic [W-1:0]  mem_b [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;

   logic enq;
   logic deq;

   assign in_rdy       = (count_q != FULL_COUNT);
   assign operands_val = (count_q != '0);
   assign enq          = in_val && in_rdy;
   assign deq          = operands_val && operands_rdy;

   assign operands_bits_A = mem_a[rd_ptr];
   assign operands_bits_B = mem_b[rd_ptr];
   assign count           = count_q;

   // Pointers are exactly PW bits wide, so incrementing past DEPTH-1 wraps
   // to 0 without an explicit compare (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         mem_a   <= '{default: '0};
         mem_b   <= '{default: '0};
      end else begin
         if (enq) begin
            mem_a[wr_ptr] <= in_bits_A;
            mem_b[wr_ptr] <= in_bits_B;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({enq, deq})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule : gcd_operand_fifo

// File: tb/tb_gcd_operand_fifo.sv
// ---------------------------------------------------------------------------
// tb_gcd_operand_fifo
//   Self-checking bench for gcd_operand_fifo. A queue of pairs stands in for
//   the FIFO; every cycle the DUT outputs are compared against it, followed
//   by directed scenario checks and a randomized phase.
// ---------------------------------------------------------------------------
module tb_gcd_operand_fifo;
   import gcd_pkg::*;

   localparam int W     = GCD_W;
   localparam int DEPTH = GCD_FIFO_DEPTH;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in_bits_A;
   logic [W-1:0]  in_bits_B;
   logic          in_val;
   logic          in_rdy;
   logic [W-1:0]  operands_bits_A;
   logic [W-1:0]  operands_bits_B;
   logic          operands_val;
   logic          operands_rdy;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   gcd_operand_fifo #(.W(W), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_bits_A       (in_bits_A),
      .in_bits_B       (in_bits_B),
      .in_val          (in_val),
      .in_rdy          (in_rdy),
      .operands_bits_A (operands_bits_A),
      .operands_bits_B (operands_bits_B),
      .operands_val    (operands_val),
      .operands_rdy    (operands_rdy),
      .count           (count)
   );

   int passed = 0;
   int total  = 0;

   // Reference: pairs currently held, oldest first, as {A, B}.
   logic [2*W-1:0] model[$];
   // A values popped by the consumer, in pop order.
   logic [W-1:0]   drained[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_outputs();
      check("in_rdy", 64'(in_rdy), 64'(model.size() != DEPTH));
      check("operands_val", 64'(operands_val), 64'(model.size() != 0));
      check("count", 64'(count), 64'(model.size()));
      if (model.size() != 0) begin
         check("head_A", 64'(operands_bits_A), 64'(model[0][2*W-1:W]));
         check("head_B", 64'(operands_bits_B), 64'(model[0][W-1:0]));
      end
   endtask

   // Check current outputs, clock once with the present inputs, update model.
   task automatic step();
      bit             enq;
      bit             deq;
      bit             rst;
      logic [2*W-1:0] pair;
      logic [2*W-1:0] head;
      check_outputs();
      enq  = in_val && (model.size() != DEPTH);
      deq  = operands_rdy && (model.size() != 0);
      rst  = reset;
      pair = {in_bits_A, in_bits_B};
      @(posedge clk);
      #1;
      if (rst) begin
         model.delete();
      end else begin
         if (deq) begin
            head = model.pop_front();
            drained.push_back(head[2*W-1:W]);
         end
         if (enq) model.push_back(pair);
      end
   endtask

   int exp_drain[5] = '{1, 3, 5, 7, 9};

   initial begin
      reset        = 1'b1;
      in_val       = 1'b0;
      in_bits_A    = '0;
      in_bits_B    = '0;
      operands_rdy = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle after reset: reset values every cycle.
      for (int i = 0; i < 3; i++) begin
         check("rst_A", 64'(operands_bits_A), 64'd0);
         check("rst_B", 64'(operands_bits_B), 64'd0);
         step();
      end

      // Single pair held at the head until consumed.
      in_val = 1'b1; in_bits_A = 27; in_bits_B = 15;
      step();
      in_val = 1'b0; in_bits_A = 0; in_bits_B = 0;
      check("one_val", 64'(operands_val), 64'd1);
      check("one_A", 64'(operands_bits_A), 64'd27);
      check("one_B", 64'(operands_bits_B), 64'd15);
      check("one_count", 64'(count), 64'd1);
      step();
      step();
      operands_rdy = 1'b1;
      step();
      operands_rdy = 1'b0;
      check("one_drained", 64'(count), 64'd0);

      // Fill to full; a fifth pair waits until there is room.
      drained.delete();
      for (int i = 0; i < 4; i++) begin
         in_val = 1'b1; in_bits_A = 2*i + 1; in_bits_B = 2*i + 2;
         step();
      end
      in_bits_A = 9; in_bits_B = 10;
      check("full_count", 64'(count), 64'd4);
      check("full_in_rdy", 64'(in_rdy), 64'd0);
      step();
      check("full_hold_count", 64'(count), 64'd4);
      operands_rdy = 1'b1;
      step();
      operands_rdy = 1'b0;
      check("after_pop_count", 64'(count), 64'd3);
      step();
      in_val = 1'b0;
      check("fifth_in_count", 64'(count), 64'd4);
      operands_rdy = 1'b1;
      for (int i = 0; i < 5; i++) step();
      operands_rdy = 1'b0;
      check("drain_len", 64'(drained.size()), 64'd5);
      for (int i = 0; i < 5 && i < drained.size(); i++)
         check("drain_order", 64'(drained[i]), 64'(exp_drain[i]));

      // Concurrent push/pop at count=2 across pointer wrap.
      drained.delete();
      in_val = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_bits_A = 100 + i; in_bits_B = i;
         step();
      end
      operands_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_bits_A = 102 + i; in_bits_B = 50 + i;
         step();
         check("steady_count", 64'(count), 64'd2);
      end
      in_val = 1'b0;
      step();
      step();
      check("steady_drain_len", 64'(drained.size()), 64'd8);
      for (int i = 0; i < 8 && i < drained.size(); i++)
         check("steady_order", 64'(drained[i]), 64'(100 + i));
      operands_rdy = 1'b0;

      // Full with push and pop together: pop only.
      in_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_bits_A = 200 + i; in_bits_B = 300 + i;
         step();
      end
      in_bits_A = 999; in_bits_B = 999;
      operands_rdy = 1'b1;
      step();
      in_val = 1'b0;
      check("full_both_count", 64'(count), 64'd3);
      check("full_both_in_rdy", 64'(in_rdy), 64'd1);
      for (int i = 0; i < 3; i++) step();
      operands_rdy = 1'b0;

      // Reset with stored pairs and live handshakes discards everything.
      in_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bits_A = 400 + i; in_bits_B = 500 + i;
         step();
      end
      reset = 1'b1; operands_rdy = 1'b1;
      step();
      reset = 1'b0; in_val = 1'b0;
      check("rst_mid_count", 64'(count), 64'd0);
      check("rst_mid_val", 64'(operands_val), 64'd0);
      check("rst_mid_in_rdy", 64'(in_rdy), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_mid_stays_empty", 64'(operands_val), 64'd0);
      end
      operands_rdy = 1'b0;

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         in_val       = 1'($urandom_range(0, 1));
         in_bits_A    = $urandom;
         in_bits_B    = $urandom;
         operands_rdy = 1'($urandom_range(0, 1));
         reset        = ($urandom_range(0, 63) == 0);
         step();
      end
      reset = 1'b0; in_val = 1'b0; operands_rdy = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_gcd_operand_fifo
